shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a shift request.
REQ-005 reqN_ready  output  1  block accepts requester N's request this cycle.
REQ-006 reqN_data  input  32  operand to shift.
REQ-007 reqN_amt  input  5  shift amount, 0..31.
REQ-008 reqN_op  input  1  0 = logical left (SLL), 1 = logical right (SRL).
REQ-009 respN_valid  output  1  result for requester N is available.
REQ-010 respN_ready  input  1  requester N consumes the result.
REQ-011 respN_data  output  32  shift result.
REQ-012 sh_a  output  32  operand to the shared external left barrel shifter.
REQ-013 sh_b  output  32  shift amount to the shifter; bits [31:5] SHALL be 0.
REQ-014 sh_out  input  32  combinational result of the shifter, (sh_a << sh_b[4:0]).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-016 In IDLE with no reqN_valid: all reqN_ready = 0 and the state SHALL hold.
REQ-017 Grant in IDLE:
- Only one valid requester: grant that requester.
- Both valid: grant the requester not recorded in last_grant.
REQ-018 reqN_ready SHALL be 1 only in IDLE, only for the granted N, and never for both ports at once.
REQ-019 On a reqN_valid && reqN_ready edge, the block SHALL:
- Capture data, amt, op and owner N.
- Set last_grant = N.
- Go to EXEC.
REQ-020 In EXEC, sh_a and sh_b SHALL be driven from the captured registers.
- SLL: sh_a = data.
- SRL: sh_a = bit-reverse(data).
- Both: sh_b = {27'b0, amt}.
REQ-021 At the end of EXEC, the block SHALL register the result and go to RESP.
- SLL: result = sh_out.
- SRL: result = bit-reverse(sh_out).
REQ-022 In RESP, resp<owner>_valid = 1 and resp<owner>_data = registered result; the other port SHALL show valid = 0.
REQ-023 While resp<owner>_ready = 0, valid and data SHALL hold stable.
REQ-024 On resp<owner>_valid && resp<owner>_ready, the block SHALL go to IDLE and drop valid on the next cycle.
REQ-025 Latency: request accepted at edge E -> respN_valid = 1 in the cycle after edge E+1.
- Minimum issue-to-issue spacing is 3 cycles.
REQ-026 Outside EXEC, sh_a and sh_b SHALL be 0.
REQ-027 Outside RESP, respN_data SHALL hold its last value and respN_valid SHALL be 0.
REQ-028 reqN_valid deasserting in EXEC or RESP SHALL have no effect on the in-flight operation.
REQ-029 Amount 0 SHALL return the operand unchanged for both ops.
REQ-030 respN_ready asserted outside RESP, or for the non-owner, SHALL be ignored.

Reset
REQ-031 While reset = 1, the following SHALL hold in the same cycle:
- reqN_ready = 0, respN_valid = 0.
- sh_a = 0, sh_b = 0.
REQ-032 On the reset edge, the block SHALL set:
- state = IDLE.
- respN_data = 0.
- last_grant = 1, so requester 0 wins the first tie.
REQ-033 Reset in EXEC or RESP SHALL discard the in-flight operation and produce no response.

Verification
REQ-034 SLL: req0 data=0x00000001, amt=4, op=0 -> resp0_data = 0x00000010, valid 2 cycles after accept.
REQ-035 SRL: req1 data=0x80000000, amt=31, op=1 -> resp1_data = 0x00000001; data=0xF0000000, amt=4 -> 0x0F000000.
REQ-036 Tie after reset:
- Stimulus: req0 and req1 both valid with data=0x0000000F, amt=1, op=0.
- Response: req0 granted first; resp0_data = 0x0000001E.
- Then req1 granted; resp1_data = 0x0000001E.
- Then, with both still valid, req0 granted again.
REQ-037 Back-pressure: resp0_ready held 0 for 5 cycles in RESP -> resp0_valid = 1 and data stable throughout; no new reqN_ready; IDLE one cycle after ready = 1.
REQ-038 Reset mid-op:
- Stimulus: reset pulsed for 1 cycle while in EXEC.
- Response: no respN_valid ever for that op; resp0_data = 0; next tie grants req0.
REQ-039 Amount zero: data=0xDEADBEEF, amt=0, op=0 and op=1 -> result 0xDEADBEEF; sh_b[31:5] = 0 in every cycle.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-port round-robin front end for one shared external left barrel shifter.
// SRL is done by bit-reversing the operand into the shifter and reversing its result.
module shift_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_amt,
   input  logic        req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_amt,
   input  logic        req1_op,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_data,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_data,
   output logic [31:0] sh_a,
   output logic [31:0] sh_b,
   input  logic [31:0] sh_out
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t      state_q, state_d;
   logic [31:0] data_q, data_d, res0_q, res0_d, res1_q, res1_d;
   logic [31:0] data_rev, out_rev, result;
   logic [4:0]  amt_q, amt_d;
   logic        op_q, op_d, own_q, own_d, last_q, last_d;
   logic        gnt0, gnt1, acc, done, in_exec;
   assign data_rev = {<<{data_q}};
   assign out_rev  = {<<{sh_out}};
   always_comb begin
      gnt0        = req0_valid && (!req1_valid || last_q);
      gnt1        = req1_valid && (!req0_valid || !last_q);
      req0_ready  = !reset && state_q == IDLE && gnt0;
      req1_ready  = !reset && state_q == IDLE && gnt1;
      acc         = req0_ready || req1_ready;
      resp0_valid = !reset && state_q == RESP && !own_q;
      resp1_valid = !reset && state_q == RESP && own_q;
      done        = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);
      in_exec     = !reset && state_q == EXEC;
      sh_a        = in_exec ? (op_q ? data_rev : data_q) : '0;
      sh_b        = in_exec ? {27'b0, amt_q} : '0;
      result      = op_q ? out_rev : sh_out;
      state_d     = state_q == IDLE ? (acc ? EXEC : IDLE) :
                    state_q == EXEC ? RESP :
                    state_q == RESP ? (done ? IDLE : RESP) : IDLE;
      data_d      = acc ? (req1_ready ? req1_data : req0_data) : data_q;
      amt_d       = acc ? (req1_ready ? req1_amt : req0_amt) : amt_q;
      op_d        = acc ? (req1_ready ? req1_op : req0_op) : op_q;
      own_d       = acc ? req1_ready : own_q;
      last_d      = acc ? req1_ready : last_q;
      res0_d      = (state_q == EXEC && !own_q) ? result : res0_q;
      res1_d      = (state_q == EXEC && own_q) ? result : res1_q;
      resp0_data  = res0_q;
      resp1_data  = res1_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         amt_q   <= '0;
         op_q    <= 1'b0;
         own_q   <= 1'b0;
         last_q  <= 1'b1;
         res0_q  <= '0;
         res1_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         amt_q   <= amt_d;
         op_q    <= op_d;
         own_q   <= own_d;
         last_q  <= last_d;
         res0_q  <= res0_d;
         res1_q  <= res1_d;
      end
   end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter with a behavioural left shifter attached.
module tb_shift_arbiter;
   logic        clk = 1'b0, reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
   logic [31:0] req0_data = '0, req1_data = '0;
   logic [4:0]  req0_amt = '0, req1_amt = '0;
   logic        req0_op = 1'b0, req1_op = 1'b0;
   logic        resp0_valid, resp1_valid, resp0_ready = 1'b1, resp1_ready = 1'b1;
   logic [31:0] resp0_data, resp1_data, sh_a, sh_b, sh_out;
   int          n_chk = 0, n_pass = 0;
   logic [32:0] sb[$];
   logic        exp_last = 1'b1;

   always #5 clk = ~clk;
   assign sh_out = sh_a << sh_b[4:0];

   shift_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req0_amt(req0_amt), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .req1_amt(req1_amt), .req1_op(req1_op),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
      .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic o);
      return o ? d >> a : d << a;
   endfunction

   task automatic pop(input logic p, input logic [31:0] d);
      logic [32:0] e;
      if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
      else begin
         e = sb.pop_front();
         check("resp_port", 32'(p), 32'(e[32]));
         check("resp_data", d, e[31:0]);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         check("sh_b_hi", 32'(sh_b[31:5]), 32'd0);
         check("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
         if (resp0_valid && resp0_ready) pop(1'b0, resp0_data);
         if (resp1_valid && resp1_ready) pop(1'b1, resp1_data);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
         k++;
         tick();
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic req(input logic v0, input logic v1, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [4:0] a0, input logic [4:0] a1, input logic o0, input logic o1);
      logic g0, g1;
      int   lat = 0;
      req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
      req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
      @(negedge clk);
      g0 = v0 && (!v1 || exp_last);
      g1 = v1 && (!v0 || !exp_last);
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      if (g0 || g1) begin
         sb.push_back(g1 ? {1'b1, model(d1, a1, o1)} : {1'b0, model(d0, a0, o0)});
         exp_last = g1;
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      while (!(resp0_valid || resp1_valid) && lat < 20) begin
         lat++;
         tick();
      end
      check("latency", 32'(lat), 32'd1);
      drain();
   endtask

   initial begin
      logic [31:0] exp;
      int          k;
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] exp;
      int          k;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      check("rst_resp0_valid", 32'(resp0_valid), 32'd0);
      check("rst_resp1_valid", 32'(resp1_valid), 32'd0);
      check("rst_sh_a", sh_a, 32'd0);
      check("rst_sh_b", sh_b, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("rst_resp0_data", resp0_data, 32'd0);
      check("rst_resp1_data", resp1_data, 32'd0);
      repeat (3) req(1'b1, 1'b1, 32'hF, 32'hF, 5'd1, 5'd1, 1'b0, 1'b0);
      req(1'b1, 1'b0, 32'h1, 32'h0, 5'd4, 5'd0, 1'b0, 1'b0);
      req(1'b0, 1'b1, 32'h0, 32'h8000_0000, 5'd0, 5'd31, 1'b0, 1'b1);
      req(1'b0, 1'b1, 32'h0, 32'hF000_0000, 5'd0, 5'd4, 1'b0, 1'b1);
      req(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
      req(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
      req(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         logic v0, v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         req(v0, v1, $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      // back-pressure: owner stalls 5 cycles while both requesters keep asking
      resp0_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_amt = 5'd8; req0_op = 1'b1;
      req1_valid = 1'b0;
      @(negedge clk);
      check("bp_grant", 32'(req0_ready), 32'd1);
      exp = model(32'h1234_5678, 5'd8, 1'b1);
      sb.push_back({1'b0, exp});
      exp_last = 1'b0;
      tick();
      req1_valid = 1'b1; req1_data = 32'h0000_00FF; req1_amt = 5'd2; req1_op = 1'b0;
      k = 0;
      while (!resp0_valid && k < 20) begin
         k++;
         tick();
      end
      repeat (5) begin
         check("bp_valid", 32'(resp0_valid), 32'd1);
         check("bp_data", resp0_data, exp);
         check("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
         tick();
      end
      resp0_ready = 1'b1;
      tick();
      check("bp_idle_valid", 32'(resp0_valid), 32'd0);
      check("bp_idle_grant", 32'(req1_ready), 32'd1);
      check("bp_drain", 32'(sb.size()), 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      // reset while the operation is in EXEC
      req0_valid = 1'b1; req0_data = 32'h0000_ABCD; req0_amt = 5'd3; req0_op = 1'b0;
      req1_valid = 1'b1; req1_data = 32'h0000_ABCD; req1_amt = 5'd3; req1_op = 1'b0;
      tick();
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_sh_a", sh_a, 32'd0);
      check("mid_rst_resp_valid", 32'({resp0_valid, resp1_valid}), 32'd0);
      tick();
      reset = 1'b0;
      exp_last = 1'b1;
      check("mid_rst_resp0_data", resp0_data, 32'd0);
      check("mid_rst_resp1_data", resp1_data, 32'd0);
      k = 0;
      repeat (5) begin
         if (resp0_valid || resp1_valid) k++;
         tick();
      end
      check("mid_rst_no_resp", 32'(k), 32'd0);
      req(1'b1, 1'b1, 32'h0000_000F, 32'h0000_000F, 5'd1, 5'd1, 1'b0, 1'b0);
      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
